// File: rtl/down_counter_ctrl_pkg.sv
// Shared types and helpers for the down-counter sequencing controller.
package down_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_PRESCALE = 4;

    // Prescaler counter width: enough bits for 0..PRESCALE-1, never less than one bit.
    function automatic int unsigned pre_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

    localparam int unsigned PRE_W = pre_width(DEFAULT_PRESCALE);

endpackage

// File: rtl/down_counter_prescaler.sv
// Prescaler for the down-counter: emits one tick every PRESCALE enabled cycles.
// The count freezes while en is low, so a paused countdown resumes mid-period.
module down_counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    import down_counter_ctrl_pkg::*;

    localparam int unsigned CNT_W = pre_width(PRESCALE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] pre_cnt_q;
    logic [CNT_W-1:0] pre_cnt_d;

    // Tick on the last enabled cycle of a period; clear has priority over counting.
    always_comb begin
        tick      = en && (pre_cnt_q == LAST);
        pre_cnt_d = pre_cnt_q;
        if (clr) begin
            pre_cnt_d = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
        end else if (en) begin
            pre_cnt_d = pre_cnt_q + CNT_W'(1);
        end
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/down_counter_ctrl.sv
// Down-counter sequencing controller: load, prescaled countdown, pause/abort,
// one-shot or auto-reload, terminal-count pulse and saturating event counter.
module down_counter_ctrl #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned PW       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse,
    output logic             err,
    output logic [PW-1:0]    tc_events
);
    import down_counter_ctrl_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_pulse_q, tc_pulse_d;
    logic             err_q, err_d;
    logic [PW-1:0]    tc_events_q, tc_events_d;

    logic             pre_clr;
    logic             pre_en;
    logic             tick;
    logic [WIDTH-1:0] eff_val;

    down_counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (pre_clr),
        .en  (pre_en),
        .tick(tick)
    );

    // Prescaler control kept apart from the FSM so tick never feeds back into en.
    always_comb begin
        eff_val = load ? load_val : count_q;
        pre_clr = 1'b0;
        pre_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: pre_clr = start && (eff_val != '0);
            ST_RUN:           begin
                pre_clr = abort;
                pre_en  = !abort && !pause;
            end
            ST_HOLD:          pre_clr = abort;
            default:          ;
        endcase
    end

    // Next-state logic: abort > pause > tick in RUN/HOLD; load before start in IDLE/DONE.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        mode_d      = mode_q;
        tc_pulse_d  = 1'b0;
        err_d       = 1'b0;
        tc_events_d = tc_events_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load) begin
                    count_d  = load_val;
                    reload_d = load_val;
                    state_d  = ST_IDLE;
                end
                if (start) begin
                    if (eff_val == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        mode_d  = auto_reload;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else if (tick) begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        tc_pulse_d = 1'b1;
                        if (tc_events_q != '1) begin
                            tc_events_d = tc_events_q + PW'(1);
                        end
                        if (mode_q) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            mode_q      <= 1'b0;
            tc_pulse_q  <= 1'b0;
            err_q       <= 1'b0;
            tc_events_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            mode_q      <= mode_d;
            tc_pulse_q  <= tc_pulse_d;
            err_q       <= err_d;
            tc_events_q <= tc_events_d;
        end
    end

    // Status outputs decoded from registered state.
    always_comb begin
        count     = count_q;
        busy      = (state_q == ST_RUN) || (state_q == ST_HOLD);
        done      = (state_q == ST_DONE);
        tc_pulse  = tc_pulse_q;
        err       = err_q;
        tc_events = tc_events_q;
    end

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed bench for down_counter_ctrl: a main instance (PRESCALE=4, PW=8) and a
// fast instance (PRESCALE=1, PW=2) for event-counter saturation.
module tb_down_counter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] load_val;
    logic       load, start, pause, abort, auto_reload;
    logic [3:0] count;
    logic       busy, done, tc_pulse, err;
    logic [7:0] tc_events;

    logic [3:0] load_val2;
    logic       load2, start2, pause2, abort2, auto2;
    logic [3:0] count2;
    logic       busy2, done2, tc2, err2;
    logic [1:0] ev2;

    down_counter_ctrl #(.WIDTH(4), .PRESCALE(4), .PW(8)) dut (
        .clk(clk), .rst(rst), .load_val(load_val), .load(load), .start(start),
        .pause(pause), .abort(abort), .auto_reload(auto_reload),
        .count(count), .busy(busy), .done(done), .tc_pulse(tc_pulse),
        .err(err), .tc_events(tc_events)
    );

    down_counter_ctrl #(.WIDTH(4), .PRESCALE(1), .PW(2)) dut_sat (
        .clk(clk), .rst(rst), .load_val(load_val2), .load(load2), .start(start2),
        .pause(pause2), .abort(abort2), .auto_reload(auto2),
        .count(count2), .busy(busy2), .done(done2), .tc_pulse(tc2),
        .err(err2), .tc_events(ev2)
    );

    // Packed observation: {count, busy, done, tc_pulse, err, events}
    typedef struct {
        string       tag;
        bit          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;

    function automatic logic [15:0] obs1();
        return {count, busy, done, tc_pulse, err, tc_events};
    endfunction

    function automatic logic [15:0] obs2();
        return {count2, busy2, done2, tc2, err2, 6'b0, ev2};
    endfunction

    task automatic expect1(input string tag, input logic [3:0] c, input logic b,
                           input logic d, input logic t, input logic e, input logic [7:0] ev);
        exp_t x;
        x.tag = tag;
        x.sel = 1'b0;
        x.exp = {c, b, d, t, e, ev};
        sb.push_back(x);
    endtask

    task automatic expect2(input string tag, input logic [3:0] c, input logic b,
                           input logic d, input logic t, input logic e, input logic [1:0] ev);
        exp_t x;
        x.tag = tag;
        x.sel = 1'b1;
        x.exp = {c, b, d, t, e, 6'b0, ev};
        sb.push_back(x);
    endtask

    // Advance one clock, sample 1ns later, and retire every queued expectation.
    task automatic step();
        exp_t        x;
        logic [15:0] o;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            o = x.sel ? obs2() : obs1();
            checks++;
            assert (o === x.exp) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", x.tag, o, x.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b0; load_val = '0; load = 0; start = 0; pause = 0; abort = 0; auto_reload = 0;
        load_val2 = '0; load2 = 0; start2 = 0; pause2 = 0; abort2 = 0; auto2 = 0;

        // Power-on reset
        step();
        expect1("reset", 4'd0, 0, 0, 0, 0, 8'd0);
        expect2("reset_sat", 4'd0, 0, 0, 0, 0, 2'd0);
        step();
        rst = 1'b1;

        // One-shot: load 3 and start together, with a load attempt mid-run
        load_val = 4'd3; load = 1; start = 1;
        expect1("oneshot_start", 4'd3, 1, 0, 0, 0, 8'd0);
        step();
        load = 0; start = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) begin
                load = 1; load_val = 4'd9;
            end
            if (k < 12)
                expect1($sformatf("oneshot k=%0d", k),
                        (k < 4) ? 4'd3 : (k < 8) ? 4'd2 : 4'd1, 1, 0, 0, 0, 8'd0);
            else
                expect1("oneshot_tc", 4'd0, 0, 1, 1, 0, 8'd1);
            step();
            load = 0;
        end
        expect1("oneshot_after", 4'd0, 0, 1, 0, 0, 8'd1);
        step();

        // Zero-value starts
        load = 1; load_val = 4'd0;
        expect1("load0_from_done", 4'd0, 0, 0, 0, 0, 8'd1);
        step();
        load = 0; start = 1;
        expect1("zero_start_err", 4'd0, 0, 0, 0, 1, 8'd1);
        step();
        start = 0;
        expect1("err_one_cycle", 4'd0, 0, 0, 0, 0, 8'd1);
        step();
        load = 1; load_val = 4'd7;
        expect1("load7", 4'd7, 0, 0, 0, 0, 8'd1);
        step();
        load_val = 4'd0; start = 1;
        expect1("load0_start_err", 4'd0, 0, 0, 0, 1, 8'd1);
        step();
        load = 0; start = 0;
        expect1("load0_start_idle", 4'd0, 0, 0, 0, 0, 8'd1);
        step();

        // Auto-reload with value 2; mode input dropped right after start
        load_val = 4'd2; load = 1; start = 1; auto_reload = 1;
        expect1("auto_start", 4'd2, 1, 0, 0, 0, 8'd1);
        step();
        load = 0; start = 0; auto_reload = 0;
        for (int k = 1; k <= 24; k++) begin
            expect1($sformatf("auto k=%0d", k),
                    ((k / 4) % 2 == 0) ? 4'd2 : 4'd1, 1, 0, (k % 8 == 0),
                    0, 8'(1 + k / 8));
            step();
        end
        abort = 1;
        expect1("auto_abort", 4'd0, 0, 0, 0, 0, 8'd4);
        step();
        abort = 0;

        // Pause after the first decrement with 2 prescaler cycles elapsed
        load_val = 4'd5; load = 1; start = 1;
        expect1("pause_start", 4'd5, 1, 0, 0, 0, 8'd4);
        step();
        load = 0; start = 0;
        for (int k = 1; k <= 6; k++) begin
            expect1($sformatf("pause_run k=%0d", k), (k < 4) ? 4'd5 : 4'd4, 1, 0, 0, 0, 8'd4);
            step();
        end
        pause = 1;
        for (int k = 0; k < 10; k++) begin
            expect1($sformatf("hold k=%0d", k), 4'd4, 1, 0, 0, 0, 8'd4);
            step();
        end
        pause = 0;
        expect1("resume_edge", 4'd4, 1, 0, 0, 0, 8'd4);
        step();
        expect1("resume_pre3", 4'd4, 1, 0, 0, 0, 8'd4);
        step();
        expect1("resume_dec", 4'd3, 1, 0, 0, 0, 8'd4);
        step();
        pause = 1;
        expect1("hold_again", 4'd3, 1, 0, 0, 0, 8'd4);
        step();
        abort = 1;
        expect1("abort_hold", 4'd0, 0, 0, 0, 0, 8'd4);
        step();
        abort = 0; pause = 0;
        expect1("abort_idle", 4'd0, 0, 0, 0, 0, 8'd4);
        step();

        // Reset on the edge that would have been the terminal tick
        load_val = 4'd1; load = 1; start = 1;
        expect1("rst_run_start", 4'd1, 1, 0, 0, 0, 8'd4);
        step();
        load = 0; start = 0;
        for (int k = 1; k <= 3; k++) begin
            expect1($sformatf("rst_run k=%0d", k), 4'd1, 1, 0, 0, 0, 8'd4);
            step();
        end
        rst = 1'b0;
        expect1("midrun_reset1", 4'd0, 0, 0, 0, 0, 8'd0);
        step();
        expect1("midrun_reset2", 4'd0, 0, 0, 0, 0, 8'd0);
        step();
        rst = 1'b1;
        expect1("post_reset", 4'd0, 0, 0, 0, 0, 8'd0);
        step();

        // Saturating event counter: PW=2, PRESCALE=1, auto-reload value 1
        load_val2 = 4'd1; load2 = 1; start2 = 1; auto2 = 1;
        expect2("sat_start", 4'd1, 1, 0, 0, 0, 2'd0);
        step();
        load2 = 0; start2 = 0;
        for (int k = 1; k <= 6; k++) begin
            expect2($sformatf("sat k=%0d", k), 4'd1, 1, 0, 1, 0, (k < 3) ? 2'(k) : 2'd3);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
